// File: rtl/wb_daq_channel_arbiter.sv
// wb_daq_channel_arbiter: shares one wb_daq_bus_master between NUM_CH acquisition channels.
// Latency: ch_req -> start 2 cycles, daq_done -> ch_ack 1 cycle; watchdog aborts WAIT after TIMEOUT cycles.
// Backpressure: channels hold ch_req until ch_ack; only one bus sequence is outstanding at a time.
// Build option: define DAQ_ARB_CH0_PRIORITY_EN to give channel 0 absolute priority over the rotation.
module wb_daq_channel_arbiter #(
   parameter int NUM_CH  = 4,
   parameter int dw      = 32,
   parameter int aw      = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                       wb_clk,
   input  logic                       wb_rst,
   input  logic [dw-1:0]              control_reg,
   input  logic                       clear_err,
   input  logic [NUM_CH-1:0]          ch_req,
   input  logic [NUM_CH*dw-1:0]       ch_data,
   input  logic [NUM_CH*aw-1:0]       ch_base,
   output logic [NUM_CH-1:0]          ch_ack,
   input  logic                       daq_done,
   output logic                       start,
   output logic [aw-1:0]              address,
   output logic [3:0]                 selection,
   output logic                       write,
   output logic [dw-1:0]              data_wr,
   output logic [NUM_CH-1:0]          grant,
   output logic                       busy,
   output logic                       timeout_err,
   output logic [$clog2(NUM_CH)-1:0]  err_ch
);

   localparam int IW = $clog2(NUM_CH);
   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_LAUNCH,
      S_WAIT,
      S_RELEASE
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_last;
   logic [IW-1:0]     r_win;
   logic [CW-1:0]     r_wdog;
   logic              r_start;
   logic              r_write;
   logic              r_busy;
   logic              r_terr;
   logic [aw-1:0]     r_addr;
   logic [dw-1:0]     r_data;
   logic [3:0]        r_sel;
   logic [NUM_CH-1:0] r_grant;
   logic [NUM_CH-1:0] r_ack;
   logic [IW-1:0]     r_err_ch;

   logic              w_win_vld;
   logic [IW-1:0]     w_win_idx;
   logic [IW-1:0]     w_cand;
   logic              w_unused_ctrl;

   // Only the global enable bit of control_reg has meaning here
   assign w_unused_ctrl = &{1'b0, control_reg[dw-1:1]};

   // Round-robin search starting just after the last granted channel, wrapping
   always_comb begin
      w_win_vld = 1'b0;
      w_win_idx = '0;
      w_cand    = '0;
`ifdef DAQ_ARB_CH0_PRIORITY_EN
      if (ch_req[0]) begin
         w_win_vld = 1'b1;
      end
`endif
      for (int k = 1; k <= NUM_CH; k++) begin
         w_cand = IW'((int'(r_last) + k) % NUM_CH);
`ifdef DAQ_ARB_CH0_PRIORITY_EN
         if (!w_win_vld && ch_req[w_cand] && (w_cand != '0)) begin
`else
         if (!w_win_vld && ch_req[w_cand]) begin
`endif
            w_win_vld = 1'b1;
            w_win_idx = w_cand;
         end
      end
   end

   // Sequencer: arbitrate, launch, wait with watchdog, release; every output is a register
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_state  <= S_IDLE;
         r_last   <= IW'(NUM_CH - 1);
         r_win    <= '0;
         r_wdog   <= '0;
         r_start  <= 1'b0;
         r_write  <= 1'b0;
         r_busy   <= 1'b0;
         r_terr   <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_sel    <= '0;
         r_grant  <= '0;
         r_ack    <= '0;
         r_err_ch <= '0;
      end else begin
         r_ack <= '0;
         // a timeout raised later in this block overrides a simultaneous clear
         if (clear_err) begin
            r_terr <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (control_reg[0] && (|ch_req)) begin
                  r_busy  <= 1'b1;
                  r_state <= S_ARB;
               end
            end
            S_ARB: begin
               if (w_win_vld) begin
                  r_win   <= w_win_idx;
                  r_grant <= NUM_CH'(1) << w_win_idx;
                  r_addr  <= ch_base[int'(w_win_idx)*aw +: aw];
                  r_data  <= ch_data[int'(w_win_idx)*dw +: dw];
                  r_sel   <= 4'hF;
                  r_write <= 1'b1;
                  r_start <= 1'b1;
                  r_state <= S_LAUNCH;
               end else begin
                  // requests vanished between IDLE and ARB
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_LAUNCH: begin
               r_start <= 1'b0;
               r_wdog  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (daq_done) begin
                  r_ack   <= r_grant;
                  r_state <= S_RELEASE;
               end else if (r_wdog == CW'(TIMEOUT - 1)) begin
                  r_terr   <= 1'b1;
                  r_err_ch <= r_win;
                  r_state  <= S_RELEASE;
               end else if (r_wdog != '1) begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            S_RELEASE: begin
               r_grant <= '0;
               r_write <= 1'b0;
               r_sel   <= '0;
`ifdef DAQ_ARB_CH0_PRIORITY_EN
               // channel 0 sits outside the rotation
               if (r_win != '0) begin
                  r_last <= r_win;
               end
`else
               r_last  <= r_win;
`endif
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ch_ack      = r_ack;
   assign start       = r_start;
   assign address     = r_addr;
   assign selection   = r_sel;
   assign write       = r_write;
   assign data_wr     = r_data;
   assign grant       = r_grant;
   assign busy        = r_busy;
   assign timeout_err = r_terr;
   assign err_ch      = r_err_ch;

endmodule

// File: tb/tb_wb_daq_channel_arbiter.sv
// tb_wb_daq_channel_arbiter: directed table, corner sequences and randomized transactions.
// Inputs are driven and outputs sampled on the falling edge of wb_clk.
`timescale 1ns/1ps
module tb_wb_daq_channel_arbiter;

   localparam int NCH = 4;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int TO  = 16;

   logic              wb_clk = 1'b0;
   logic              wb_rst = 1'b0;
   logic [DW-1:0]     control_reg = '0;
   logic              clear_err = 1'b0;
   logic [NCH-1:0]    ch_req = '0;
   logic [NCH*DW-1:0] ch_data = '0;
   logic [NCH*AW-1:0] ch_base = '0;
   logic              daq_done = 1'b0;
   logic [NCH-1:0]    ch_ack;
   logic              start;
   logic [AW-1:0]     address;
   logic [3:0]        selection;
   logic              write;
   logic [DW-1:0]     data_wr;
   logic [NCH-1:0]    grant;
   logic              busy;
   logic              timeout_err;
   logic [1:0]        err_ch;

   always #5 wb_clk = ~wb_clk;

   wb_daq_channel_arbiter #(.NUM_CH(NCH), .dw(DW), .aw(AW), .TIMEOUT(TO)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .control_reg(control_reg), .clear_err(clear_err),
      .ch_req(ch_req), .ch_data(ch_data), .ch_base(ch_base), .ch_ack(ch_ack),
      .daq_done(daq_done), .start(start), .address(address), .selection(selection),
      .write(write), .data_wr(data_wr), .grant(grant), .busy(busy),
      .timeout_err(timeout_err), .err_ch(err_ch)
   );

   int n_checks = 0;
   int n_err    = 0;
   int m_last;
   logic [31:0] b_base [NCH];
   logic [31:0] b_data [NCH];

   typedef struct {
      logic [3:0] req;
      int         dly;
      logic [3:0] exp_grant;
      bit         exp_to;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference arbitration rule: first requester in rotation after the last grant
   function automatic int model_pick(input logic [3:0] req, input int last);
      int order[$];
`ifdef DAQ_ARB_CH0_PRIORITY_EN
      if (req[0]) return 0;
`endif
      for (int off = 1; off <= NCH; off++) order.push_back((last + off) % NCH);
      foreach (order[i]) begin
`ifdef DAQ_ARB_CH0_PRIORITY_EN
         if (order[i] == 0) continue;
`endif
         if (req[order[i]]) return order[i];
      end
      return -1;
   endfunction

   function automatic void model_commit(input int w);
`ifdef DAQ_ARB_CH0_PRIORITY_EN
      if (w != 0) m_last = w;
`else
      m_last = w;
`endif
   endfunction

   function automatic int onehot_idx(input logic [3:0] g);
      for (int i = 0; i < NCH; i++) if (g[i]) return i;
      return 0;
   endfunction

   task automatic drive_bus();
      for (int i = 0; i < NCH; i++) begin
         ch_base[i*AW +: AW] = b_base[i];
         ch_data[i*DW +: DW] = b_data[i];
      end
   endtask

   task automatic wait_start(output int n);
      n = 0;
      for (int i = 1; i <= 8 && n == 0; i++) begin
         @(negedge wb_clk);
         if (start) n = i;
      end
   endtask

   // One complete transaction starting from an observed IDLE cycle
   task automatic run_txn(input logic [3:0] req, input int dly, input logic [3:0] exp_grant,
                          input bit exp_to, input bit drop_req, input bit spur);
      int w, n, ack_j, to_j, idle_j, acks;
      logic [3:0] ack_val;
      logic [31:0] e_addr, e_data;
      bit held_ok;
      w = onehot_idx(exp_grant);
      for (int i = 0; i < NCH; i++) begin
         b_base[i] = $urandom;
         b_data[i] = $urandom;
      end
      drive_bus();
      e_addr = b_base[w];
      e_data = b_data[w];
      ch_req = req;
      n = 0;
      for (int i = 1; i <= 8 && n == 0; i++) begin
         @(negedge wb_clk);
         if (start) n = i;
         daq_done = spur && ($urandom_range(0, 1) == 1);
      end
      chk("start_latency", n, 2);
      if (n == 0) begin
         daq_done = 1'b0;
         return;
      end
      chk("grant", grant, exp_grant);
      chk("address", address, e_addr);
      chk("data_wr", data_wr, e_data);
      chk("sel_write_busy", {selection, write, busy}, {4'hF, 1'b1, 1'b1});
      if (drop_req) ch_req = '0;
      for (int i = 0; i < NCH; i++) begin
         b_base[i] = $urandom;
         b_data[i] = $urandom;
      end
      drive_bus();
      acks = 0; ack_j = -1; to_j = -1; idle_j = -1; held_ok = 1'b1; ack_val = '0;
      for (int j = 1; j <= 40 && idle_j < 0; j++) begin
         @(negedge wb_clk);
         if (ch_ack != '0) begin
            acks++;
            ack_j   = j;
            ack_val = ch_ack;
         end
         if (timeout_err && to_j < 0) to_j = j;
         if (busy) begin
            if (start || grant != exp_grant || address != e_addr || data_wr != e_data) held_ok = 1'b0;
         end else begin
            idle_j = j;
         end
         daq_done = (j == dly) || (spur && j > dly && $urandom_range(0, 1) == 1);
      end
      daq_done = 1'b0;
      chk("held_stable", held_ok, 1);
      if (!exp_to) begin
         chk("ack_count", acks, 1);
         chk("ack_cycle", ack_j, dly + 1);
         chk("ack_value", ack_val, exp_grant);
         chk("no_timeout", timeout_err, 0);
         chk("idle_cycle", idle_j, dly + 2);
      end else begin
         chk("timeout_no_ack", acks, 0);
         chk("timeout_cycle", to_j, TO + 1);
         chk("err_ch", err_ch, w);
         chk("timeout_idle", idle_j, TO + 2);
      end
      chk("release_outs", {grant, write, selection, ch_ack, start}, 0);
      model_commit(w);
      if (exp_to) begin
         ch_req    = '0;
         clear_err = 1'b1;
         @(negedge wb_clk);
         clear_err = 1'b0;
         chk("clear_err", {timeout_err, busy}, 0);
         chk("err_ch_kept", err_ch, w);
      end
   endtask

   initial begin
      int n, w, dly;
      bit any_act;
      logic [3:0] req;

`ifdef DAQ_ARB_CH0_PRIORITY_EN
      tbl[0]  = '{4'b0100,  6, 4'b0100, 1'b0};
      tbl[1]  = '{4'b1111,  3, 4'b0001, 1'b0};
      tbl[2]  = '{4'b1111,  3, 4'b0001, 1'b0};
      tbl[3]  = '{4'b1110,  3, 4'b1000, 1'b0};
      tbl[4]  = '{4'b1110,  3, 4'b0010, 1'b0};
      tbl[5]  = '{4'b1110,  3, 4'b0100, 1'b0};
      tbl[6]  = '{4'b1110,  3, 4'b1000, 1'b0};
      tbl[7]  = '{4'b0010, 30, 4'b0010, 1'b1};
      tbl[8]  = '{4'b0011, 16, 4'b0001, 1'b0};
      tbl[9]  = '{4'b0010,  1, 4'b0010, 1'b0};
      tbl[10] = '{4'b1001, 17, 4'b0001, 1'b1};
      tbl[11] = '{4'b1000,  2, 4'b1000, 1'b0};
`else
      tbl[0]  = '{4'b0100,  6, 4'b0100, 1'b0};
      tbl[1]  = '{4'b1111,  3, 4'b1000, 1'b0};
      tbl[2]  = '{4'b1111,  3, 4'b0001, 1'b0};
      tbl[3]  = '{4'b1111,  3, 4'b0010, 1'b0};
      tbl[4]  = '{4'b1111,  3, 4'b0100, 1'b0};
      tbl[5]  = '{4'b1111,  3, 4'b1000, 1'b0};
      tbl[6]  = '{4'b1111,  3, 4'b0001, 1'b0};
      tbl[7]  = '{4'b0010, 30, 4'b0010, 1'b1};
      tbl[8]  = '{4'b0011, 16, 4'b0001, 1'b0};
      tbl[9]  = '{4'b0011,  1, 4'b0010, 1'b0};
      tbl[10] = '{4'b1001, 17, 4'b1000, 1'b1};
      tbl[11] = '{4'b1001,  2, 4'b0001, 1'b0};
`endif

      // reset state
      #2 wb_rst = 1'b1;
      repeat (3) @(negedge wb_clk);
      chk("reset_addr_data", {address, data_wr}, 0);
      chk("reset_ctrl", {start, selection, write, grant, busy, timeout_err, err_ch, ch_ack}, 0);
      wb_rst      = 1'b0;
      control_reg = 32'hFFFF_FFF1;
      m_last      = NCH - 1;

      // directed table
      for (int t = 0; t < 12; t++) begin
         run_txn(tbl[t].req, tbl[t].dly, tbl[t].exp_grant, tbl[t].exp_to, 1'b0, 1'b0);
      end

      // enable dropped mid-sequence: current transfer finishes, nothing new starts
      ch_req = 4'b0100;
      w = model_pick(ch_req, m_last);
      wait_start(n);
      chk("dis_start_latency", n, 2);
      control_reg = '0;
      @(negedge wb_clk);
      daq_done = 1'b1;
      @(negedge wb_clk);
      daq_done = 1'b0;
      chk("dis_ack", ch_ack, 4'b0001 << w);
      any_act = 1'b0;
      @(negedge wb_clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge wb_clk);
         if (busy || start || grant != '0) any_act = 1'b1;
      end
      chk("dis_no_new_arb", any_act, 0);
      model_commit(w);
      ch_req      = '0;
      control_reg = 32'h1;

      // reset asserted in the middle of WAIT
      ch_req = 4'b0100;
      wait_start(n);
      chk("rst_start_latency", n, 2);
      repeat (3) @(negedge wb_clk);
      wb_rst   = 1'b1;
      daq_done = 1'b1;
      #1;
      chk("rst_async_addr_data", {address, data_wr}, 0);
      chk("rst_async_ctrl", {start, selection, write, grant, busy, ch_ack}, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge wb_clk);
         chk("rst_no_ack", ch_ack, 0);
      end
      wb_rst   = 1'b0;
      daq_done = 1'b0;
      ch_req   = '0;
      m_last   = NCH - 1;
      run_txn(4'b1111, 4, 4'b0001, 1'b0, 1'b0, 1'b0);

      // randomized transactions against the reference rule
      for (int t = 0; t < 40; t++) begin
         req = 4'($urandom_range(1, 15));
         dly = $urandom_range(1, 20);
         w   = model_pick(req, m_last);
         if (w < 0) w = 0;
         run_txn(req, dly, 4'b0001 << w, dly > TO, $urandom_range(0, 3) == 0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_daq_channel_arbiter.md
Name: wb_daq_channel_arbiter

Overview:
Shares one wb_daq_bus_master between NUM_CH acquisition channels. Each channel presents one sample at a time, along with the base address of its vector descriptor. The arbiter picks one requesting channel and drives the bus master's start/address/selection/write/data_wr inputs with that channel's request. It then waits for the master's completion pulse and acknowledges the channel. A timeout watchdog stops a hung bus master from stalling the DAQ subsystem.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
dw, 32, data width
aw, 32, address width
TIMEOUT, 1024, max cycles in WAIT before abort (>=2)

Ports:
wb_clk  input  1  system clock
wb_rst  input  1  asynchronous active-high reset
control_reg  input  dw  bit0 = global enable; other bits ignored
clear_err  input  1  single-cycle pulse; clears timeout_err
ch_req  input  NUM_CH  per-channel level request, held until ch_ack
ch_data  input  NUM_CH*dw  sample per channel, channel i at [i*dw +: dw]
ch_base  input  NUM_CH*aw  descriptor base per channel, channel i at [i*aw +: aw]
ch_ack  output  NUM_CH  one-cycle pulse: granted channel's sample written
daq_done  input  1  one-cycle pulse from bus master when its sequence returns to idle
start  output  1  one-cycle launch pulse to bus master
address  output  aw  descriptor base of granted channel
selection  output  4  byte select to bus master
write  output  1  write request to bus master
data_wr  output  dw  captured sample
grant  output  NUM_CH  one-hot granted channel, 0 when none
busy  output  1  high in every state except IDLE
timeout_err  output  1  sticky timeout flag
err_ch  output  $clog2(NUM_CH)  channel index of last timeout

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; last-grant pointer = NUM_CH-1, so ch0 is considered first; state = IDLE.
- Assertion of wb_rst at any time forces the reset values on the next edge. This includes mid-WAIT; no ch_ack is issued for the aborted channel.
- State machine:
  - IDLE: if control_reg[0] && |ch_req, go to ARB; else stay.
  - ARB: choose a winner round-robin, searching from last_grant+1 and wrapping modulo NUM_CH. Register grant one-hot, address = ch_base[winner], data_wr = ch_data[winner], selection = 4'hF, write = 1. Go to LAUNCH.
  - ARB, no request: if ch_req has dropped to 0 by ARB, go back to IDLE with grant = 0.
  - LAUNCH: start = 1 for exactly this cycle; clear the watchdog counter; go to WAIT.
  - WAIT: start = 0. address, data_wr, selection, write and grant are held stable.
  - WAIT, on daq_done: pulse ch_ack[winner] for one cycle and go to RELEASE.
  - WAIT, watchdog: when the counter reaches TIMEOUT-1 without daq_done, set timeout_err = 1, set err_ch = winner, issue no ack, and go to RELEASE.
  - RELEASE: grant = 0, write = 0, selection = 0; last_grant = winner; go to IDLE.
- Latency:
  - ch_req high in IDLE → start high 2 cycles later.
  - daq_done → ch_ack high 1 cycle later.
  - Minimum request-to-request spacing is 5 cycles plus the bus master time.
- daq_done outside WAIT is ignored.
- If daq_done arrives on the same cycle the counter reaches TIMEOUT-1, done wins: ack is issued and no error is set.
- A channel whose ch_req drops after ARB is still serviced with its captured data and still receives ch_ack.
- Clearing control_reg[0] mid-sequence lets the current sequence complete; no new ARB follows.
- timeout_err and err_ch:
  - A timed-out channel stays requesting and is retried in later rounds under normal rotation.
  - If clear_err and a new timeout occur on the same cycle, the set wins.
  - err_ch keeps its value until the next timeout.
- Watchdog counter width is $clog2(TIMEOUT)+1 and saturates; it does not wrap.

Optional Feature:
DAQ_ARB_CH0_PRIORITY_EN
- Defined: in ARB, ch_req[0] always wins when asserted. Otherwise round-robin among channels 1..NUM_CH-1, with last_grant updated only by those channels.
- Undefined: pure round-robin across all channels, as described in Behaviour.

Test Plan:
- Single request: reset, enable=1, ch_req=4'b0100, ch_base[2]=32'h1000, ch_data[2]=32'hCAFE0002, daq_done 6 cycles after start → start 2 cycles after req, address=32'h1000, data_wr=32'hCAFE0002, grant=4'b0100, one ch_ack[2] pulse 1 cycle after done.
- Round-robin: ch_req=4'b1111 held, done returned 3 cycles after each start → grant order ch0, ch1, ch2, ch3, ch0; no channel granted twice within 4 grants.
- Timeout: TIMEOUT=16, ch_req=4'b0010, daq_done never pulsed → after 16 WAIT cycles timeout_err=1, err_ch=1, no ch_ack; clear_err pulse → timeout_err=0.
- Done/timeout collision: daq_done pulsed exactly on the counter = TIMEOUT-1 cycle → ch_ack pulses, timeout_err stays 0.
- Reset mid-WAIT: assert wb_rst 3 cycles after start → all outputs 0 immediately; no ch_ack; after release, the next grant goes to ch0.
- With DAQ_ARB_CH0_PRIORITY_EN: ch_req=4'b1111 held → ch0 granted every round; with ch0 dropped → ch1, ch2, ch3 rotate.
